fpu_cmd_sequencer: RTL

Wishbone-slave command sequencer that drives the FPU's logic-analyser-style command bus (operands, opcode, rounding mode, clear, activate) and collects its result word and exception flags. It lets firmware on the management core run FPU operations through memory-mapped registers instead of LA probes. It sits between the user-project Wishbone port and the FPU datapath, and raises an interrupt on completion.

---
 rtl/fpu_seq_pkg.sv | 57 +++++
 rtl/fpu_cmd_sequencer_if.sv | 23 ++
 rtl/fpu_seq_wb_regs.sv | 121 ++++++++++++
 rtl/fpu_cmd_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared definitions for the FPU command sequencer.
//   - register word indices (byte address bits [4:2])
//   - FPU opcode constants
//   - sequencer FSM state encoding
//   - STATUS / fpu_flags bit positions and a STATUS packing helper
package fpu_seq_pkg;

    localparam logic [2:0] REG_OPA     = 3'd0;   // 0x00
    localparam logic [2:0] REG_OPB     = 3'd1;   // 0x04
    localparam logic [2:0] REG_CTRL    = 3'd2;   // 0x08
    localparam logic [2:0] REG_STATUS  = 3'd3;   // 0x0C
    localparam logic [2:0] REG_RESULT  = 3'd4;   // 0x10
    localparam logic [2:0] REG_IRQ_CLR = 3'd5;   // 0x14

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_SQRT = 3'd3;
    localparam logic [2:0] OP_CMP  = 3'd4;

    localparam int CTRL_START_BIT = 8;

    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_TIMEOUT   = 2;
    localparam int ST_WR_IGN    = 3;
    localparam int ST_FLAGS_LSB = 4;

    // fpu_flags = {done, inexact, ov, un, less, eq, great, inv, div_zero}
    localparam int FLG_DONE = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4
    } seq_state_t;

    function automatic logic [31:0] pack_status(
        input logic       busy,
        input logic       done,
        input logic       timeout,
        input logic       wr_ignored,
        input logic [8:0] flags
    );
        logic [31:0] s;
        s                              = '0;
        s[ST_BUSY]                     = busy;
        s[ST_DONE]                     = done;
        s[ST_TIMEOUT]                  = timeout;
        s[ST_WR_IGN]                   = wr_ignored;
        s[ST_FLAGS_LSB+8:ST_FLAGS_LSB] = flags;
        return s;
    endfunction

endpackage

// File: rtl/fpu_cmd_sequencer_if.sv
// fpu_cmd_sequencer_if: Wishbone slave-port bundle for the FPU command sequencer.
//   master modport: bus side (management core), drives stb/cyc/we/sel/adr/dat_i
//   slave modport : sequencer side, returns ack and read data
interface fpu_cmd_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/fpu_seq_wb_regs.sv
// fpu_seq_wb_regs: Wishbone decode, single-cycle ack and register file.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wbs                 Wishbone slave bundle
//   busy                sequencer not idle; blocks operand/control updates
//   cap_valid           sequencer is in CAPTURE this cycle
//   cap_timeout         the operation being captured ended by timeout
//   cap_result/flags    live FPU result and flags to capture
//   opa, opb, opcode,   registered operand/control values fed to the FPU
//   round
//   start               combinational: accepted START write this cycle
//   irq_clr             combinational: IRQ_CLR write this cycle
module fpu_seq_wb_regs
    import fpu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    fpu_cmd_sequencer_if.slave wbs,
    input  logic        busy,
    input  logic        cap_valid,
    input  logic        cap_timeout,
    input  logic [31:0] cap_result,
    input  logic [8:0]  cap_flags,
    output logic [31:0] opa,
    output logic [31:0] opb,
    output logic [2:0]  opcode,
    output logic [2:0]  round,
    output logic        start,
    output logic        irq_clr
);

    logic        req;
    logic        wr;
    logic        rd;
    logic [2:0]  idx;
    logic        wr_opa;
    logic        wr_opb;
    logic        wr_ctrl;
    logic        cfg_blocked;
    logic        done;
    logic        timeout;
    logic        wr_ignored;
    logic [8:0]  flags;
    logic [31:0] result;
    logic [31:0] rd_data;
    logic        unused_adr;

    // A new transfer is only taken while ack is low, so acks never go back-to-back.
    assign req = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~wbs.wbs_ack_o;
    // Partial-width writes are acked but have no effect anywhere.
    assign wr  = req & wbs.wbs_we_i & (wbs.wbs_sel_i == 4'hF);
    assign rd  = req & ~wbs.wbs_we_i;
    assign idx = wbs.wbs_adr_i[4:2];

    assign wr_opa      = wr && (idx == REG_OPA);
    assign wr_opb      = wr && (idx == REG_OPB);
    assign wr_ctrl     = wr && (idx == REG_CTRL);
    assign irq_clr     = wr && (idx == REG_IRQ_CLR);
    assign cfg_blocked = busy & (wr_opa | wr_opb | wr_ctrl);
    assign start       = wr_ctrl & ~busy & wbs.wbs_dat_i[CTRL_START_BIT];

    assign unused_adr = ^{wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0]};

    always_comb begin
        rd_data = '0;
        case (idx)
            REG_OPA:    rd_data = opa;
            REG_OPB:    rd_data = opb;
            REG_CTRL:   rd_data = {26'd0, round, opcode};
            REG_STATUS: rd_data = pack_status(busy, done, timeout, wr_ignored, flags);
            REG_RESULT: rd_data = result;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
            opa           <= '0;
            opb           <= '0;
            opcode        <= '0;
            round         <= '0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            wr_ignored    <= 1'b0;
            flags         <= '0;
            result        <= '0;
        end else begin
            wbs.wbs_ack_o <= req;
            wbs.wbs_dat_o <= rd ? rd_data : 32'd0;

            if (wr_opa && !busy) opa <= wbs.wbs_dat_i;
            if (wr_opb && !busy) opb <= wbs.wbs_dat_i;
            if (wr_ctrl && !busy) begin
                opcode <= wbs.wbs_dat_i[2:0];
                round  <= wbs.wbs_dat_i[5:3];
            end
            if (start) begin
                done    <= 1'b0;
                timeout <= 1'b0;
                flags   <= '0;
            end
            if (cfg_blocked) wr_ignored <= 1'b1;

            if (irq_clr) begin
                done       <= 1'b0;
                timeout    <= 1'b0;
                wr_ignored <= 1'b0;
            end
            // Placed last so a completion landing with IRQ_CLR is not lost.
            if (cap_valid) begin
                result  <= cap_result;
                flags   <= cap_flags;
                done    <= 1'b1;
                timeout <= cap_timeout;
            end
        end
    end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer: Wishbone-controlled sequencer that runs one FPU operation
// per START (clear pulse, activate, wait for done or timeout, capture result).
// Optional macro: FPU_SEQ_IRQ_EN -- builds the completion interrupt register;
// when undefined irq is tied low and firmware polls STATUS.
// Ports:
//   wb_clk_i, wb_rst_ni   clock, async active-low reset
//   wbs                   Wishbone slave bundle (register access)
//   fpu_in1/in2           operands (frozen while busy)
//   fpu_opcode/round      operation and rounding mode
//   fpu_rst               one-cycle FPU clear pulse
//   fpu_act               FPU activate, held through WAIT
//   fpu_out/fpu_flags     FPU result and {done, ..., div_zero}
//   irq                   completion interrupt
//
// state     | meaning
// ----------+------------------------------------------------------
// S_IDLE    | waiting for START; busy=0
// S_CLEAR   | drives the one-cycle fpu_rst pulse
// S_ISSUE   | raises fpu_act, loads the wait timer
// S_WAIT    | fpu_act held; exit on fpu done or timer terminal count
// S_CAPTURE | result/flags captured, done (and timeout) set, fpu_act drops
module fpu_cmd_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    fpu_cmd_sequencer_if.slave wbs,
    output logic [31:0] fpu_in1,
    output logic [31:0] fpu_in2,
    output logic [2:0]  fpu_opcode,
    output logic [2:0]  fpu_round,
    output logic        fpu_rst,
    output logic        fpu_act,
    input  logic [31:0] fpu_out,
    input  logic [8:0]  fpu_flags,
    output logic        irq
);

    // Down-counter with terminal count at zero: loaded with TIMEOUT_CYCLES-1 on
    // entry so the WAIT exit happens on the TIMEOUT_CYCLES-th WAIT sample. It
    // stops at zero rather than wrapping.
    localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT_CYCLES - 1);

    seq_state_t state;
    logic [7:0] wait_cnt;
    logic       exit_timeout;
    logic       busy;
    logic       start;
    logic       irq_clr;
    logic       cap_valid;

    assign busy      = (state != S_IDLE);
    assign cap_valid = (state == S_CAPTURE);

    fpu_seq_wb_regs u_regs (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_ni),
        .wbs         (wbs),
        .busy        (busy),
        .cap_valid   (cap_valid),
        .cap_timeout (exit_timeout),
        .cap_result  (fpu_out),
        .cap_flags   (fpu_flags),
        .opa         (fpu_in1),
        .opb         (fpu_in2),
        .opcode      (fpu_opcode),
        .round       (fpu_round),
        .start       (start),
        .irq_clr     (irq_clr)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            exit_timeout <= 1'b0;
            fpu_rst      <= 1'b0;
            fpu_act      <= 1'b0;
        end else begin
            fpu_rst <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        exit_timeout <= 1'b0;
                        state        <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    fpu_rst <= 1'b1;
                    state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    fpu_act  <= 1'b1;
                    wait_cnt <= WAIT_LOAD;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A done seen on the terminal-count sample still counts as a
                    // normal completion.
                    if (fpu_flags[FLG_DONE]) begin
                        state <= S_CAPTURE;
                    end else if (wait_cnt == 8'd0) begin
                        exit_timeout <= 1'b1;
                        state        <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_CAPTURE: begin
                    fpu_act <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    fpu_act <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FPU_SEQ_IRQ_EN
    // Set in the same cycle that done is set so both win over a coincident IRQ_CLR.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq <= 1'b0;
        end else if (cap_valid) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule
